vx_mem_port_arbiter: RTL and testbench
======================================

// Module: vx_mem_port_arbiter
// PURPOSE
//  Shares one external memory port among NUM_REQS requesters, e.g. per-cluster L2 memory ports when the L3 is bypassed.
//  Round-robin arbitration on requests; the requester index is appended to the tag.
//  Responses are routed back by tag. Outstanding reads are limited by a credit counter.
//  Sits between per-cluster memory buses and the top-level memory interface.
// PARAMETERS
//  NUM_REQS     4    number of requesters (>=1)
//  ADDR_WIDTH   26   line address width
//  DATA_WIDTH   512  line data width; byteen width = DATA_WIDTH/8
//  TAG_WIDTH    8    requester tag width
//  MAX_PENDING  16   max outstanding reads (>=1)
//  derived: SEL_W = max(1, clog2(NUM_REQS)); OUT_TAG_W = TAG_WIDTH + SEL_W; CNT_W = clog2(MAX_PENDING+1)
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high reset
//  in_req_valid   in   NUM_REQS            per-requester request valid
//  in_req_rw      in   NUM_REQS            1 = write
//  in_req_byteen  in   NUM_REQS*DATA/8     byte enables
//  in_req_addr    in   NUM_REQS*ADDR       line address
//  in_req_data    in   NUM_REQS*DATA       write data
//  in_req_tag     in   NUM_REQS*TAG        request tag
//  in_req_ready   out  NUM_REQS            request accepted
//  in_rsp_valid   out  NUM_REQS            routed response valid
//  in_rsp_data    out  NUM_REQS*DATA       response data, broadcast to all requesters
//  in_rsp_tag     out  NUM_REQS*TAG        original tag, broadcast to all requesters
//  in_rsp_ready   in   NUM_REQS            requester can take response
//  out_req_valid/rw/byteen/addr/data  out  memory request fields
//  out_req_tag    out  OUT_TAG_W           {in_tag, sel}; sel in the LSBs
//  out_req_ready  in   1                   memory accepts request
//  out_rsp_valid  in   1; out_rsp_data in DATA; out_rsp_tag in OUT_TAG_W
//  out_rsp_ready  out  1                   = in_rsp_ready[out_rsp_tag[SEL_W-1:0]]
//  pending_count  out  CNT_W               outstanding reads
//  busy           out  1                   pending_count!=0 || output buffer non-empty
// BEHAVIOUR
//  - Reset: out_req_valid=0, in_req_ready=0, buffer empty, rr pointer=0, pending_count=0, busy=0.
//  - Grant: combinational round-robin among valid requesters, searching from ptr.
//    A read is eligible only if pending_count + staged_reads < MAX_PENDING; writes are always eligible.
//  - Accept: a grant is issued only when the buffer can accept. in_req_ready is one-hot on the grant.
//    On fire, ptr <= grant+1 (mod NUM_REQS). ptr is unchanged on idle cycles.
//  - Output stage: 2-entry elastic (skid) buffer. Request latency is 1 cycle (fire -> out_req_valid).
//    Sustains 1 request per cycle under continuous out_req_ready.
//    out_req fields are held stable while valid && !ready.
//  - Credit: pending_count +1 on an out_req fire with rw=0, -1 on an out_rsp fire; both in one cycle -> unchanged.
//    Reads staged in the buffer also consume credit, so pending never exceeds MAX_PENDING.
//  - Response path: zero latency, combinational. in_rsp_valid[i] = out_rsp_valid && sel==i.
//    in_rsp_tag = out_rsp_tag[OUT_TAG_W-1:SEL_W]. sel >= NUM_REQS is never produced; assert on it.
//  - Underflow (rsp with pending_count==0): assertion fires; counter holds at 0.
//  - NUM_REQS==1: sel is constant 0 (1 bit); arbitration degenerates to passthrough plus buffer.
//  - Reset mid-operation: buffer contents dropped, counter cleared; late responses are still routed.
// STRUCTURE
//  - VX_gpu_pkg: function arb_sel_width(n) and the OUT_TAG_W derivation, so the top level can size memory tags.
//  - Sub-module vx_rr_arbiter: NUM_REQS valids + enable -> one-hot grant, index, fire-driven pointer.
//  - Output buffer: reuse the existing elastic buffer, SIZE=2.
// TESTING
//  1 Single read, req1 tag=0x2A, addr=0x100 -> out_req_tag={0x2A,2'd1} next cycle; pending 0->1.
//    Rsp with that tag -> in_rsp_valid[1], in_rsp_tag=0x2A; pending 1->0.
//  2 All 4 requesters valid continuously, out_req_ready=1, writes only -> grants 0,1,2,3,0... in order; 1 req/cycle.
//  3 MAX_PENDING=2, three reads from req0, no responses -> 2 issued; third stalls (ready=0).
//    One response -> third issues the next cycle.
//  4 out_req_ready=0 for 5 cycles with valids held -> out_req fields stable, at most 2 accepted.
//    Release -> drains in grant order.
//  5 Read fire and response fire in the same cycle with pending=3 -> pending stays 3.
//    Response for req2 with in_rsp_ready[2]=0 -> out_rsp_ready=0.
//  6 Reset asserted with 2 buffered requests and pending=5 -> next cycle out_req_valid=0, pending=0, busy=0.
//    Grant order restarts at requester 0.

Source files
------------

// File: rtl/vx_mem_port_arbiter_pkg.sv
// Shared sizing helpers for the memory port arbiter. The top level of the
// GPU uses these to size the memory-side tag before instantiating the
// arbiter, so both sides agree on how many select bits get appended.
package vx_mem_port_arbiter_pkg;

  // Requester-select width; never zero so a single-requester build still
  // carries a (constant 0) select bit in the tag.
  function automatic int arb_sel_width(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Memory-side tag width: original requester tag plus select in the LSBs.
  function automatic int out_tag_width(input int tag_width, input int num_reqs);
    return tag_width + arb_sel_width(num_reqs);
  endfunction

  // Width needed to count 0..max_pending outstanding reads.
  function automatic int credit_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   valid        per-requester candidate mask
//   enable       allow a grant this cycle
//   grant        one-hot grant (all zero when no grant)
//   grant_idx    index of the granted requester
//   grant_valid  a grant is issued this cycle (treated as the fire)
module vx_rr_arbiter
  import vx_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int SEL_W = arb_sel_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [SEL_W-1:0] ptr;
  logic             found;

  // Two passes: first the requesters at or above the pointer, then wrap to
  // the lowest valid index. Equivalent to searching circularly from ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && valid[i] && (SEL_W'(i) >= ptr)) begin
        found     = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && valid[i]) begin
        found     = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
  end

  assign grant_valid = found && enable;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      grant[i] = grant_valid && (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/vx_mem_port_arbiter.sv
// Shares one memory port among NUM_REQS requesters. Requests are arbitrated
// round-robin, the winner index is appended to the tag, and the request is
// registered into a 2-entry skid buffer. Responses are routed back by the
// select bits of the tag with no added latency. Outstanding reads (issued
// plus staged in the buffer) are capped at MAX_PENDING.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_req_*                   per-requester request bundles (flattened)
//   in_rsp_*                   per-requester response (data/tag broadcast)
//   out_req_*                  memory request, tag = {in_tag, sel}
//   out_rsp_*                  memory response
//   pending_count              reads issued to memory and not yet answered
//   busy                       reads outstanding or requests buffered
module vx_mem_port_arbiter
  import vx_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int SEL_W     = arb_sel_width(NUM_REQS),
  localparam int OUT_TAG_W = out_tag_width(TAG_WIDTH, NUM_REQS),
  localparam int CNT_W     = credit_width(MAX_PENDING),
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            in_req_valid,
  input  logic [NUM_REQS-1:0]            in_req_rw,
  input  logic [NUM_REQS*BE_W-1:0]       in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_REQS-1:0]            in_req_ready,
  output logic [NUM_REQS-1:0]            in_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0] in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]  in_rsp_tag,
  input  logic [NUM_REQS-1:0]            in_rsp_ready,
  output logic                           out_req_valid,
  output logic                           out_req_rw,
  output logic [BE_W-1:0]                out_req_byteen,
  output logic [ADDR_WIDTH-1:0]          out_req_addr,
  output logic [DATA_WIDTH-1:0]          out_req_data,
  output logic [OUT_TAG_W-1:0]           out_req_tag,
  input  logic                           out_req_ready,
  input  logic                           out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          out_rsp_data,
  input  logic [OUT_TAG_W-1:0]           out_rsp_tag,
  output logic                           out_rsp_ready,
  output logic [CNT_W-1:0]               pending_count,
  output logic                           busy
);

  // Buffer entry layout, MSB first: {rw, byteen, addr, data, tag+sel}
  localparam int ENTRY_W = 1 + BE_W + ADDR_WIDTH + DATA_WIDTH + OUT_TAG_W;

  logic [1:0]          buf_count;
  logic [ENTRY_W-1:0]  buf_q [2];
  logic                buf_push;
  logic                buf_pop;
  logic [ENTRY_W-1:0]  sel_entry;
  logic [NUM_REQS-1:0] req_elig;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [1:0]          staged_reads;
  logic                credit_ok;
  logic                rd_fire;
  logic                rsp_fire;
  logic [SEL_W-1:0]    rsp_sel;

  // Reads sitting in the buffer already hold a credit, so a burst of reads
  // cannot overshoot MAX_PENDING while waiting for out_req_ready.
  assign staged_reads = {1'b0, (buf_count != 2'd0) && !buf_q[0][ENTRY_W-1]}
                      + {1'b0, (buf_count == 2'd2) && !buf_q[1][ENTRY_W-1]};
  assign credit_ok = ({1'b0, pending_count} + (CNT_W+1)'(staged_reads))
                     < (CNT_W+1)'(MAX_PENDING);

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_elig[i] = in_req_valid[i] && (in_req_rw[i] || credit_ok);
    end
  end

  // Accept depends only on buffer occupancy, not on out_req_ready, so there
  // is no combinational path from the memory side back to the requesters.
  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid       (req_elig),
    .enable      (!reset && (buf_count != 2'd2)),
    .grant       (in_req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_entry = {in_req_rw[i],
                     in_req_byteen[i*BE_W +: BE_W],
                     in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                     in_req_data[i*DATA_WIDTH +: DATA_WIDTH],
                     in_req_tag[i*TAG_WIDTH +: TAG_WIDTH],
                     SEL_W'(i)};
      end
    end
  end

  assign buf_push      = grant_valid;
  assign out_req_valid = (buf_count != 2'd0);
  assign buf_pop       = out_req_valid && out_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_count <= 2'd0;
    end else begin
      buf_count <= buf_count + {1'b0, buf_push} - {1'b0, buf_pop};
    end
  end

  // Head is always entry 0; a push lands in the first free slot after the pop.
  always_ff @(posedge clk) begin
    if (buf_pop) begin
      buf_q[0] <= buf_q[1];
    end
    if (buf_push) begin
      if ((buf_count - {1'b0, buf_pop}) == 2'd0) begin
        buf_q[0] <= sel_entry;
      end else begin
        buf_q[1] <= sel_entry;
      end
    end
  end

  assign {out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag} = buf_q[0];

  assign rd_fire  = buf_pop && !out_req_rw;
  assign rsp_fire = out_rsp_valid && out_rsp_ready;

  // A response with nothing outstanding is a protocol error; hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_count <= '0;
    end else if (rd_fire && !rsp_fire) begin
      pending_count <= pending_count + CNT_W'(1);
    end else if (!rd_fire && rsp_fire && (pending_count != '0)) begin
      pending_count <= pending_count - CNT_W'(1);
    end
  end

  assign rsp_sel = out_rsp_tag[SEL_W-1:0];

  always_comb begin
    out_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      in_rsp_valid[i] = out_rsp_valid && (rsp_sel == SEL_W'(i));
      if (rsp_sel == SEL_W'(i)) begin
        out_rsp_ready = in_rsp_ready[i];
      end
    end
  end

  assign in_rsp_data = {NUM_REQS{out_rsp_data}};
  assign in_rsp_tag  = {NUM_REQS{out_rsp_tag[OUT_TAG_W-1:SEL_W]}};

  assign busy = (pending_count != '0) || (buf_count != 2'd0);

  sel_in_range: assert property (@(posedge clk) disable iff (reset)
    out_rsp_valid |-> (32'(rsp_sel) < 32'(NUM_REQS)));

  no_underflow: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> (pending_count != '0));

endmodule

// File: tb/tb_vx_mem_port_arbiter.sv
module tb_vx_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   in_req_valid, in_req_rw;
  logic [15:0]  in_req_byteen;
  logic [103:0] in_req_addr;
  logic [127:0] in_req_data;
  logic [31:0]  in_req_tag;
  logic [3:0]   in_rsp_ready;
  logic         out_req_ready, out_rsp_valid, out_rsp_valid2;
  logic [31:0]  out_rsp_data;
  logic [9:0]   out_rsp_tag;

  logic [3:0]   in_req_ready, in_rsp_valid;
  logic [127:0] in_rsp_data;
  logic [31:0]  in_rsp_tag;
  logic         out_req_valid, out_req_rw, out_rsp_ready, busy;
  logic [3:0]   out_req_byteen;
  logic [25:0]  out_req_addr;
  logic [31:0]  out_req_data;
  logic [9:0]   out_req_tag;
  logic [4:0]   pending_count;

  logic [3:0]   m2_in_req_ready, m2_in_rsp_valid;
  logic [127:0] m2_in_rsp_data;
  logic [31:0]  m2_in_rsp_tag;
  logic         m2_out_req_valid, m2_out_req_rw, m2_out_rsp_ready, m2_busy;
  logic [3:0]   m2_out_req_byteen;
  logic [25:0]  m2_out_req_addr;
  logic [31:0]  m2_out_req_data;
  logic [9:0]   m2_out_req_tag;
  logic [1:0]   m2_pending_count;

  vx_mem_port_arbiter #(.NUM_REQS(4), .ADDR_WIDTH(26), .DATA_WIDTH(32),
                        .TAG_WIDTH(8), .MAX_PENDING(16)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_byteen(out_req_byteen),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .pending_count(pending_count), .busy(busy)
  );

  vx_mem_port_arbiter #(.NUM_REQS(4), .ADDR_WIDTH(26), .DATA_WIDTH(32),
                        .TAG_WIDTH(8), .MAX_PENDING(2)) dut_mp2 (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(m2_in_req_ready),
    .in_rsp_valid(m2_in_rsp_valid), .in_rsp_data(m2_in_rsp_data), .in_rsp_tag(m2_in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(m2_out_req_valid), .out_req_rw(m2_out_req_rw), .out_req_byteen(m2_out_req_byteen),
    .out_req_addr(m2_out_req_addr), .out_req_data(m2_out_req_data), .out_req_tag(m2_out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid2), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(m2_out_rsp_ready),
    .pending_count(m2_pending_count), .busy(m2_busy)
  );

  int tests = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v, rw;
    logic       ordy, rspv;
    logic [9:0] rtag;
    logic [3:0] rrdy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [9:0] e_tag;
    logic [25:0] e_addr;
    logic       e_rw;
    logic [4:0] e_pend;
    logic       e_busy;
    logic [3:0] e_rspv;
    logic       e_ordy;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] rw, logic ordy,
                              logic rspv, logic [9:0] rtag, logic [3:0] rrdy,
                              logic [3:0] e_rdy, logic e_ov, logic [9:0] e_tag,
                              logic [25:0] e_addr, logic e_rw, logic [4:0] e_pend,
                              logic e_busy, logic [3:0] e_rspv, logic e_ordy);
    vec_t t;
    t.rst = rst; t.v = v; t.rw = rw; t.ordy = ordy; t.rspv = rspv; t.rtag = rtag;
    t.rrdy = rrdy; t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_tag = e_tag; t.e_addr = e_addr;
    t.e_rw = e_rw; t.e_pend = e_pend; t.e_busy = e_busy; t.e_rspv = e_rspv; t.e_ordy = e_ordy;
    return t;
  endfunction

  vec_t tbl[24];

  task automatic idle_inputs();
    in_req_valid = 4'b0; in_req_rw = 4'b0; out_req_ready = 1'b1;
    out_rsp_valid = 1'b0; out_rsp_valid2 = 1'b0; out_rsp_tag = 10'h0; in_rsp_ready = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  int fires;

  initial begin
    // Requester tags 0x11, 0x2A, 0x22, 0x33; addresses 0x000/0x100/0x200/0x300.
    in_req_tag    = {8'h33, 8'h22, 8'h2A, 8'h11};
    in_req_addr   = {26'h300, 26'h200, 26'h100, 26'h000};
    in_req_data   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    in_req_byteen = 16'hFFFF;
    out_rsp_data  = 32'h0;
    idle_inputs();
    reset = 1'b1;

    //          rst v       rw      ordy rspv rtag    rrdy   e_rdy   ov tag     addr    rw pend busy rspv   ordy
    tbl[0]  = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[1]  = mk(0, 4'b0010, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0010, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[2]  = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 1, 10'h0A9, 26'h100, 0, 0, 1, 4'b0000, 0);
    tbl[3]  = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 1, 1, 4'b0000, 0);
    tbl[4]  = mk(0, 4'b0000, 4'b0000, 1, 1, 10'h0A9, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 1, 1, 4'b0010, 1);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[6]  = mk(1, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[7]  = mk(0, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b0001, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[8]  = mk(0, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b0010, 1, 10'h044, 26'h000, 1, 0, 1, 4'b0000, 0);
    tbl[9]  = mk(0, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b0100, 1, 10'h0A9, 26'h100, 1, 0, 1, 4'b0000, 0);
    tbl[10] = mk(0, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b1000, 1, 10'h08A, 26'h200, 1, 0, 1, 4'b0000, 0);
    tbl[11] = mk(0, 4'b1111, 4'b1111, 1, 0, 10'h000, 4'hF, 4'b0001, 1, 10'h0CF, 26'h300, 1, 0, 1, 4'b0000, 0);
    tbl[12] = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 1, 10'h044, 26'h000, 1, 0, 1, 4'b0000, 0);
    tbl[13] = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[14] = mk(1, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[15] = mk(0, 4'b0001, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0001, 0, 10'h000, 26'h000, 0, 0, 0, 4'b0000, 0);
    tbl[16] = mk(0, 4'b0001, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0001, 1, 10'h044, 26'h000, 0, 0, 1, 4'b0000, 0);
    tbl[17] = mk(0, 4'b0001, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0001, 1, 10'h044, 26'h000, 0, 1, 1, 4'b0000, 0);
    tbl[18] = mk(0, 4'b0001, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0001, 1, 10'h044, 26'h000, 0, 2, 1, 4'b0000, 0);
    tbl[19] = mk(0, 4'b0000, 4'b0000, 1, 1, 10'h044, 4'hF, 4'b0000, 1, 10'h044, 26'h000, 0, 3, 1, 4'b0001, 1);
    tbl[20] = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 3, 1, 4'b0000, 0);
    tbl[21] = mk(0, 4'b0000, 4'b0000, 1, 1, 10'h08A, 4'hB, 4'b0000, 0, 10'h000, 26'h000, 0, 3, 1, 4'b0100, 0);
    tbl[22] = mk(0, 4'b0000, 4'b0000, 1, 1, 10'h044, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 3, 1, 4'b0001, 1);
    tbl[23] = mk(0, 4'b0000, 4'b0000, 1, 0, 10'h000, 4'hF, 4'b0000, 0, 10'h000, 26'h000, 0, 2, 1, 4'b0000, 0);

    repeat (3) @(negedge clk);

    // Table: single read round trip, write round-robin, credit with
    // simultaneous read/response, response routing with backpressure.
    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      reset = tbl[r].rst; in_req_valid = tbl[r].v; in_req_rw = tbl[r].rw;
      out_req_ready = tbl[r].ordy; out_rsp_valid = tbl[r].rspv;
      out_rsp_tag = tbl[r].rtag; in_rsp_ready = tbl[r].rrdy;
      out_rsp_data = 32'hCAFE0000 + 32'(r);
      #1;
      chk($sformatf("r%0d in_req_ready", r), in_req_ready, tbl[r].e_rdy);
      chk($sformatf("r%0d out_req_valid", r), out_req_valid, tbl[r].e_ov);
      if (tbl[r].e_ov) begin
        chk($sformatf("r%0d out_req_tag", r), out_req_tag, tbl[r].e_tag);
        chk($sformatf("r%0d out_req_addr", r), out_req_addr, tbl[r].e_addr);
        chk($sformatf("r%0d out_req_rw", r), out_req_rw, tbl[r].e_rw);
      end
      chk($sformatf("r%0d pending", r), pending_count, tbl[r].e_pend);
      chk($sformatf("r%0d busy", r), busy, tbl[r].e_busy);
      chk($sformatf("r%0d in_rsp_valid", r), in_rsp_valid, tbl[r].e_rspv);
      if (tbl[r].rspv) begin
        chk($sformatf("r%0d out_rsp_ready", r), out_rsp_ready, tbl[r].e_ordy);
        chk($sformatf("r%0d in_rsp_tag0", r), in_rsp_tag[7:0], tbl[r].rtag[9:2]);
        chk($sformatf("r%0d in_rsp_tag3", r), in_rsp_tag[31:24], tbl[r].rtag[9:2]);
        chk($sformatf("r%0d in_rsp_data2", r), in_rsp_data[95:64], 32'hCAFE0000 + 32'(r));
      end
    end

    // Credit limit of 2: third read stalls until a response returns.
    do_reset();
    fires = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_req_valid = 4'b0001; in_req_rw = 4'b0000; out_req_ready = 1'b1;
      #1;
      fires += $countones(m2_in_req_ready);
      if (c >= 3) chk($sformatf("mp2 stall c%0d", c), m2_in_req_ready, 4'b0000);
    end
    chk("mp2 pending at limit", m2_pending_count, 2'd2);
    chk("mp2 reads accepted", fires, 2);
    @(negedge clk);
    out_rsp_valid2 = 1'b1; out_rsp_tag = 10'h044; in_rsp_ready = 4'hF;
    #1;
    chk("mp2 stall on rsp cycle", m2_in_req_ready, 4'b0000);
    chk("mp2 out_rsp_ready", m2_out_rsp_ready, 1'b1);
    chk("mp2 in_rsp_valid", m2_in_rsp_valid, 4'b0001);
    @(negedge clk);
    out_rsp_valid2 = 1'b0;
    #1;
    chk("mp2 pending after rsp", m2_pending_count, 2'd1);
    chk("mp2 third accepted", m2_in_req_ready, 4'b0001);
    @(negedge clk);
    in_req_valid = 4'b0000;
    #1;
    chk("mp2 third issued", m2_out_req_valid, 1'b1);
    chk("mp2 third tag", m2_out_req_tag, 10'h044);

    // Memory backpressure: at most two accepted, head held stable, drains in order.
    do_reset();
    fires = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_req_valid = 4'b1111; in_req_rw = 4'b1111; out_req_ready = 1'b0;
      #1;
      fires += $countones(in_req_ready);
      if (c >= 2) begin
        chk($sformatf("stall c%0d valid", c), out_req_valid, 1'b1);
        chk($sformatf("stall c%0d tag", c), out_req_tag, 10'h044);
        chk($sformatf("stall c%0d data", c), out_req_data, 32'hD0);
      end
    end
    chk("stall accepted", fires, 2);
    @(negedge clk);
    in_req_valid = 4'b0000; out_req_ready = 1'b1;
    #1;
    chk("drain0 tag", out_req_tag, 10'h044);
    @(negedge clk); #1;
    chk("drain1 valid", out_req_valid, 1'b1);
    chk("drain1 tag", out_req_tag, 10'h0A9);
    chk("drain1 data", out_req_data, 32'hD1);
    @(negedge clk); #1;
    chk("drain2 valid", out_req_valid, 1'b0);
    chk("drain2 busy", busy, 1'b0);

    // Reset with two buffered reads and five outstanding.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_req_valid = 4'b0001; in_req_rw = 4'b0000; out_req_ready = 1'b1;
    end
    @(negedge clk);
    out_req_ready = 1'b0;
    @(negedge clk); #1;
    chk("pre-reset pending", pending_count, 5'd5);
    chk("pre-reset full", in_req_ready, 4'b0000);
    chk("pre-reset valid", out_req_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_req_valid = 4'b1111; in_req_rw = 4'b1111; out_req_ready = 1'b1;
    #1;
    chk("post-reset valid", out_req_valid, 1'b0);
    chk("post-reset pending", pending_count, 5'd0);
    chk("post-reset busy", busy, 1'b0);
    chk("post-reset grant", in_req_ready, 4'b0001);
    @(negedge clk); #1;
    chk("post-reset grant2", in_req_ready, 4'b0010);
    chk("post-reset tag", out_req_tag, 10'h044);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
